// File: rtl/ysyx_24090018_pc_gen.sv
// Fetch-stage PC generator: issues fetch addresses over valid/ready and handles redirects, traps and stalls.
// Optional target-alignment checking is enabled by defining YSYX_24090018_PC_ALIGN_CHECK_EN.
module ysyx_24090018_pc_gen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned INST_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  trap_valid_i,
  input  logic [ADDR_WIDTH-1:0] trap_pc_i,
  output logic                  pc_valid_o,
  input  logic                  pc_ready_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  misalign_o
);

  localparam logic [ADDR_WIDTH-1:0] RST_PC  = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(INST_BYTES);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    pend_trap_q, pend_trap_d;
  logic                    pend_redir_q, pend_redir_d;
  logic [ADDR_WIDTH-1:0]   pend_trap_pc_q, pend_trap_pc_d;
  logic [ADDR_WIDTH-1:0]   pend_redir_pc_q, pend_redir_pc_d;
  logic                    fire;
  logic                    trap_ok;
  logic                    redir_ok;

`ifdef YSYX_24090018_PC_ALIGN_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INST_BYTES - 1);

  function automatic logic is_aligned(input logic [ADDR_WIDTH-1:0] addr);
    return (addr & ALIGN_MASK) == '0;
  endfunction

  logic misalign_q, misalign_d;

  // A misaligned trap is dropped but still suppresses a same-cycle redirect.
  assign trap_ok    = trap_valid_i && is_aligned(trap_pc_i);
  assign redir_ok   = redirect_valid_i && !trap_valid_i && is_aligned(redirect_pc_i);
  assign misalign_d = (state_q != BOOT) &&
                      ((trap_valid_i && !is_aligned(trap_pc_i)) ||
                       (redirect_valid_i && !trap_valid_i && !is_aligned(redirect_pc_i)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign misalign_o = misalign_q;
`else
  assign trap_ok    = trap_valid_i;
  assign redir_ok   = redirect_valid_i && !trap_valid_i;
  assign misalign_o = 1'b0;
`endif

  assign pc_valid_o = (state_q == ISSUE);
  assign fire       = pc_valid_o && pc_ready_i;
  assign pc_o       = pc_q;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pend_trap_d     = pend_trap_q;
    pend_redir_d    = pend_redir_q;
    pend_trap_pc_d  = pend_trap_pc_q;
    pend_redir_pc_d = pend_redir_pc_q;
    unique case (state_q)
      BOOT: state_d = ISSUE;
      ISSUE: begin
        if (fire) begin
          if (pend_trap_q)       pc_d = pend_trap_pc_q;
          else if (pend_redir_q) pc_d = pend_redir_pc_q;
          else if (trap_ok)      pc_d = trap_pc_i;
          else if (redir_ok)     pc_d = redirect_pc_i;
          else                   pc_d = pc_q + PC_STEP;
          pend_trap_d  = 1'b0;
          pend_redir_d = 1'b0;
          state_d      = stall_i ? HOLD : ISSUE;
        end else if (trap_ok) begin
          pend_trap_d    = 1'b1;
          pend_trap_pc_d = trap_pc_i;
          pend_redir_d   = 1'b0;
        end else if (redir_ok && !pend_trap_q) begin
          // Later redirects overwrite earlier buffered ones.
          pend_redir_d    = 1'b1;
          pend_redir_pc_d = redirect_pc_i;
        end
      end
      HOLD: begin
        if (trap_ok)       pc_d = trap_pc_i;
        else if (redir_ok) pc_d = redirect_pc_i;
        if (!stall_i) state_d = ISSUE;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RST_PC;
      pend_trap_q  <= 1'b0;
      pend_redir_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_trap_q  <= pend_trap_d;
      pend_redir_q <= pend_redir_d;
    end
  end

  // Target buffers are only meaningful while their pending flag is set.
  always_ff @(posedge clk) begin
    pend_trap_pc_q  <= pend_trap_pc_d;
    pend_redir_pc_q <= pend_redir_pc_d;
  end

endmodule

// File: tb/tb_ysyx_24090018_pc_gen.sv
// Scoreboard bench for ysyx_24090018_pc_gen: a 32-bit instance for the main flow and an 8-bit one for wrap/async reset.
module tb_ysyx_24090018_pc_gen;

`ifdef YSYX_24090018_PC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, redir_v, trap_v, ready;
  logic [31:0] redir_pc, trap_pc;
  logic        pc_valid, misalign;
  logic [31:0] pc;

  logic        rst2, stall2, redir_v2, trap_v2, ready2;
  logic [7:0]  redir_pc2, trap_pc2;
  logic        pc_valid2, misalign2;
  logic [7:0]  pc2;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp2_q[$];
  logic [31:0] exp_mis;

  always #5 clk = ~clk;

  ysyx_24090018_pc_gen dut (
    .clk(clk), .rst(rst), .stall_i(stall),
    .redirect_valid_i(redir_v), .redirect_pc_i(redir_pc),
    .trap_valid_i(trap_v), .trap_pc_i(trap_pc),
    .pc_valid_o(pc_valid), .pc_ready_i(ready), .pc_o(pc), .misalign_o(misalign)
  );

  ysyx_24090018_pc_gen #(.ADDR_WIDTH(8), .RESET_PC(32'h0000_00FC), .INST_BYTES(4)) dut2 (
    .clk(clk), .rst(rst2), .stall_i(stall2),
    .redirect_valid_i(redir_v2), .redirect_pc_i(redir_pc2),
    .trap_valid_i(trap_v2), .trap_pc_i(trap_pc2),
    .pc_valid_o(pc_valid2), .pc_ready_i(ready2), .pc_o(pc2), .misalign_o(misalign2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (pc_valid && ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL fire_unexpected: got %h expected no handshake", pc);
      end else begin
        chk("fire_pc", pc, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (pc_valid2 && ready2) begin
      if (exp2_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL fire2_unexpected: got %h expected no handshake", pc2);
      end else begin
        chk("fire2_pc", {24'h0, pc2}, exp2_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redir_v = 1'b0; trap_v = 1'b0; ready = 1'b1;
    redir_pc = '0; trap_pc = '0;
    rst2 = 1'b1; stall2 = 1'b0; redir_v2 = 1'b0; trap_v2 = 1'b0; ready2 = 1'b1;
    redir_pc2 = '0; trap_pc2 = '0;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_valid", {31'h0, pc_valid}, 32'h0);
      chk("rst_pc", pc, 32'h8000_0000);
    end
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    chk("rst2_valid", {31'h0, pc_valid2}, 32'h0);
    rst = 1'b0;
    chk("boot_valid", {31'h0, pc_valid}, 32'h0);
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h8000_0004);
    step(); step(); step();
    ready = 1'b0;

    // Backpressure at 8000_0008
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", {31'h0, pc_valid}, 32'h1);
      chk("bp_pc", pc, 32'h8000_0008);
      step();
    end
    exp_q.push_back(32'h8000_0008);
    exp_q.push_back(32'h8000_000C);
    ready = 1'b1;
    step(); step();

    // Stall at fire of 8000_0010, redirect while in HOLD
    chk("pre_stall_pc", pc, 32'h8000_0010);
    stall = 1'b1;
    exp_q.push_back(32'h8000_0010);
    step();
    chk("hold_valid", {31'h0, pc_valid}, 32'h0);
    chk("hold_pc", pc, 32'h8000_0014);
    redir_v = 1'b1; redir_pc = 32'h8000_0040;
    step();
    redir_v = 1'b0;
    chk("hold_redir_pc", pc, 32'h8000_0040);
    chk("hold_redir_valid", {31'h0, pc_valid}, 32'h0);
    stall = 1'b0;
    step();
    ready = 1'b0;
    chk("unstall_valid", {31'h0, pc_valid}, 32'h1);

    // Buffered redirect overridden by a later trap
    redir_v = 1'b1; redir_pc = 32'h8000_0100;
    step();
    redir_v = 1'b0;
    step();
    trap_v = 1'b1; trap_pc = 32'h8000_0200;
    step();
    trap_v = 1'b0;
    chk("buf_pc_held", pc, 32'h8000_0040);
    chk("buf_valid", {31'h0, pc_valid}, 32'h1);
    exp_q.push_back(32'h8000_0040);
    exp_q.push_back(32'h8000_0200);
    ready = 1'b1;
    step(); step();

    // Same-cycle trap and redirect at fire: trap wins
    exp_q.push_back(32'h8000_0204);
    trap_v = 1'b1; trap_pc = 32'h8000_0300;
    redir_v = 1'b1; redir_pc = 32'h8000_0500;
    step();
    trap_v = 1'b0; redir_v = 1'b0;
    exp_q.push_back(32'h8000_0300);

    // Misaligned redirect at fire
    exp_mis = ALIGN_EN ? 32'h8000_0304 : 32'h8000_0102;
    redir_v = 1'b1; redir_pc = 32'h8000_0102;
    step();
    redir_v = 1'b0;
    chk("misalign_pulse", {31'h0, misalign}, {31'h0, ALIGN_EN});
    exp_q.push_back(exp_mis);
    step();
    ready = 1'b0;
    chk("misalign_clear", {31'h0, misalign}, 32'h0);
    chk("after_mis_pc", pc, exp_mis + 32'h4);
    step();

    // 8-bit instance: wrap FC -> 00, then async reset mid-request
    exp2_q.push_back(32'h0000_00FC);
    exp2_q.push_back(32'h0000_0000);
    exp2_q.push_back(32'h0000_0004);
    rst2 = 1'b0;
    step(); step(); step(); step();
    #2;
    rst2 = 1'b1;
    #1;
    chk("async_rst_valid", {31'h0, pc_valid2}, 32'h0);
    chk("async_rst_pc", {24'h0, pc2}, 32'h0000_00FC);
    chk("dut2_misalign", {31'h0, misalign2}, 32'h0);
    step(); step();

    chk("queue_empty", exp_q.size(), 32'h0);
    chk("queue2_empty", exp2_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
